// File: rtl/time_set_keypad.sv
// time_set_keypad
// Front end for the clock's time-setting controls. The raw K0/K1/K2/QD
// switches are synchronised and debounced on the main clock. The block then
// turns them into single-cycle hour/minute increment pulses, with
// press-and-hold auto-repeat. A set-mode level and a seconds-clear pulse are
// also derived from the debounced K0.

module time_set_keypad #(
  parameter int DB_CYCLES  = 20,
  parameter int RPT_DELAY  = 500,
  parameter int RPT_PERIOD = 100,
  parameter int CNT_W      = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic k0,
  input  logic k1,
  input  logic k2,
  input  logic qd,
  output logic set_mode,
  output logic sec_clr,
  output logic hour_inc,
  output logic min_inc
);

  // Channel indices into the packed switch vectors.
  localparam int CH_K0 = 0;
  localparam int CH_K1 = 1;
  localparam int CH_K2 = 2;
  localparam int CH_QD = 3;
  localparam int N_CH  = 4;

  // Terminal counts, pre-sized to the timer width.
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(RPT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------
  logic [N_CH-1:0]  raw_s;
  logic [N_CH-1:0]  sync1_r;
  logic [N_CH-1:0]  sync2_r;
  logic [N_CH-1:0]  db_r;
  logic [N_CH-1:0]  db_nx_s;
  logic [CNT_W-1:0] db_cnt_r    [N_CH];
  logic [CNT_W-1:0] db_cnt_nx_s [N_CH];

  logic             set_mode_d_r;
  logic             sec_clr_r;
  logic             sec_clr_nx_s;

  logic             go_s;
  logic             pulse_s;
  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_nx_s;

  logic             hour_nx_s;
  logic             min_nx_s;
  logic             hour_inc_r;
  logic             min_inc_r;

  assign raw_s = {qd, k2, k1, k0};

  // ---------------------------------------------------------------------
  // Synchroniser: two flops per raw input before anything looks at it
  // ---------------------------------------------------------------------

  // Two-stage synchroniser for all four switch inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: per-channel disagreement counter. The accepted level only
  // flips after DB_CYCLES consecutive samples that differ from it. Any
  // matching sample in between restarts the count, which is what rejects
  // short glitches.
  // ---------------------------------------------------------------------

  // Next debounced level and counter for each channel.
  always_comb begin
    db_nx_s = db_r;
    for (int i = 0; i < N_CH; i++) begin
      db_cnt_nx_s[i] = CNT_ZERO;
      if (sync2_r[i] != db_r[i]) begin
        if (db_cnt_r[i] == DB_LAST) begin
          db_nx_s[i]     = sync2_r[i];
          db_cnt_nx_s[i] = CNT_ZERO;
        end else begin
          db_nx_s[i]     = db_r[i];
          db_cnt_nx_s[i] = db_cnt_r[i] + CNT_ONE;
        end
      end else begin
        db_nx_s[i]     = db_r[i];
        db_cnt_nx_s[i] = CNT_ZERO;
      end
    end
  end

  // Debounced levels and their counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_r <= 4'b0000;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      db_r <= db_nx_s;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt_r[i] <= db_cnt_nx_s[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Set mode / seconds clear
  // ---------------------------------------------------------------------

  // Seconds clear fires only on the rising edge of the debounced K0.
  always_comb begin
    sec_clr_nx_s = db_r[CH_K0] & ~set_mode_d_r;
  end

  // Delayed set-mode copy for edge detection, plus the registered pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_mode_d_r <= 1'b0;
      sec_clr_r    <= 1'b0;
    end else begin
      set_mode_d_r <= db_r[CH_K0];
      sec_clr_r    <= sec_clr_nx_s;
    end
  end

  // ---------------------------------------------------------------------
  // Auto-repeat FSM: one shared timer. It counts the initial hold delay
  // in DELAY and the repeat period in REPEAT. It is cleared on every
  // pulse and whenever the FSM drops back to IDLE, so it never wraps.
  // ---------------------------------------------------------------------

  // Adjust is live only in set mode, with the button held and a target chosen.
  always_comb begin
    go_s = db_r[CH_K0] & db_r[CH_QD] & (db_r[CH_K1] | db_r[CH_K2]);
  end

  // FSM state and timer registers, plus the registered increment outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      timer_r    <= CNT_ZERO;
      hour_inc_r <= 1'b0;
      min_inc_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      timer_r    <= timer_nx_s;
      hour_inc_r <= hour_nx_s;
      min_inc_r  <= min_nx_s;
    end
  end

  // Next-state, timer and pulse-request logic.
  always_comb begin
    state_nx_s = IDLE;
    timer_nx_s = CNT_ZERO;
    pulse_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (go_s) begin
          pulse_s    = 1'b1;
          timer_nx_s = CNT_ZERO;
          state_nx_s = DELAY;
        end else begin
          pulse_s    = 1'b0;
          timer_nx_s = CNT_ZERO;
          state_nx_s = IDLE;
        end
      end
      DELAY: begin
        if (!go_s) begin
          pulse_s    = 1'b0;
          timer_nx_s = CNT_ZERO;
          state_nx_s = IDLE;
        end else if (timer_r == DELAY_LAST) begin
          pulse_s    = 1'b1;
          timer_nx_s = CNT_ZERO;
          state_nx_s = REPEAT;
        end else begin
          pulse_s    = 1'b0;
          timer_nx_s = timer_r + CNT_ONE;
          state_nx_s = DELAY;
        end
      end
      REPEAT: begin
        if (!go_s) begin
          pulse_s    = 1'b0;
          timer_nx_s = CNT_ZERO;
          state_nx_s = IDLE;
        end else if (timer_r == PERIOD_LAST) begin
          pulse_s    = 1'b1;
          timer_nx_s = CNT_ZERO;
          state_nx_s = REPEAT;
        end else begin
          pulse_s    = 1'b0;
          timer_nx_s = timer_r + CNT_ONE;
          state_nx_s = REPEAT;
        end
      end
      default: begin
        pulse_s    = 1'b0;
        timer_nx_s = CNT_ZERO;
        state_nx_s = IDLE;
      end
    endcase
  end

  // Route each pulse to the current target. The target is sampled on every
  // pulse rather than latched at the start of the hold, with K1 having priority.
  always_comb begin
    hour_nx_s = 1'b0;
    min_nx_s  = 1'b0;
    if (pulse_s) begin
      if (db_r[CH_K1]) begin
        hour_nx_s = 1'b1;
        min_nx_s  = 1'b0;
      end else if (db_r[CH_K2]) begin
        hour_nx_s = 1'b0;
        min_nx_s  = 1'b1;
      end else begin
        hour_nx_s = 1'b0;
        min_nx_s  = 1'b0;
      end
    end else begin
      hour_nx_s = 1'b0;
      min_nx_s  = 1'b0;
    end
  end

  assign set_mode = db_r[CH_K0];
  assign sec_clr  = sec_clr_r;
  assign hour_inc = hour_inc_r;
  assign min_inc  = min_inc_r;

endmodule

// File: tb/tb_time_set_keypad.sv
// tb_time_set_keypad
// Self-checking bench for time_set_keypad. A cycle-level reference model
// describes the behaviour from the outside. Each switch is delayed by two
// samples and accepted after a run of DB disagreeing samples. Pulses are
// derived from how long the enable has been continuously high. The model
// checks every output on every cycle. Table-driven scenarios and
// hand-written sequences check pulse counts and pulse times against
// hand-derived constants.

module tb_time_set_keypad;

  localparam int DB = 20;
  localparam int RD = 500;
  localparam int RP = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic k0 = 1'b0, k1 = 1'b0, k2 = 1'b0, qd = 1'b0;
  logic set_mode, sec_clr, hour_inc, min_inc;

  time_set_keypad #(
    .DB_CYCLES (DB),
    .RPT_DELAY (RD),
    .RPT_PERIOD(RP),
    .CNT_W     (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .k0      (k0),
    .k1      (k1),
    .k2      (k2),
    .qd      (qd),
    .set_mode(set_mode),
    .sec_clr (sec_clr),
    .hour_inc(hour_inc),
    .min_inc (min_inc)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state (index 0=k0, 1=k1, 2=k2, 3=qd)
  bit [3:0] hist1, hist2;     // raw values one and two samples ago
  bit [3:0] m_lvl;            // accepted levels
  int       m_run [4];        // length of the current disagreement run
  bit       m_set_prev;
  int       m_hold;           // consecutive edges with enable seen high
  bit       e_set, e_sec, e_hour, e_min;

  // Observed DUT activity since the last reset
  int cyc;
  int cnt_hour, cnt_min, cnt_sec;
  int hour_t[$];
  int min_t[$];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%b required=%b", nm, cyc, act, exp);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
  endtask

  task automatic model_reset();
    hist1 = 4'b0000; hist2 = 4'b0000; m_lvl = 4'b0000;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_set_prev = 1'b0; m_hold = 0;
    e_set = 1'b0; e_sec = 1'b0; e_hour = 1'b0; e_min = 1'b0;
  endtask

  // One clock edge of the reference model; raw = inputs present before the edge.
  task automatic model_step(input bit [3:0] raw);
    bit go;
    bit pulse;
    go = m_lvl[0] && m_lvl[3] && (m_lvl[1] || m_lvl[2]);
    if (go) m_hold++; else m_hold = 0;
    pulse = go && (m_hold == 1 || m_hold == RD + 1 ||
                   (m_hold > RD + 1 && ((m_hold - 1 - RD) % RP) == 0));
    e_hour = pulse && m_lvl[1];
    e_min  = pulse && !m_lvl[1];
    e_sec  = m_lvl[0] && !m_set_prev;
    m_set_prev = m_lvl[0];
    for (int i = 0; i < 4; i++) begin
      if (hist2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = hist2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    hist2 = hist1;
    hist1 = raw;
    e_set = m_lvl[0];
  endtask

  // Drive inputs just after an edge, clock once, compare just after the next edge.
  task automatic tick(input bit a0, input bit a1, input bit a2, input bit aq);
    k0 = a0; k1 = a1; k2 = a2; qd = aq;
    @(posedge clk);
    model_step({aq, a2, a1, a0});
    cyc++;
    #1;
    chk("set_mode", set_mode, e_set);
    chk("sec_clr",  sec_clr,  e_sec);
    chk("hour_inc", hour_inc, e_hour);
    chk("min_inc",  min_inc,  e_min);
    if (hour_inc === 1'b1) begin cnt_hour++; hour_t.push_back(cyc); end
    if (min_inc  === 1'b1) begin cnt_min++;  min_t.push_back(cyc);  end
    if (sec_clr  === 1'b1) cnt_sec++;
  endtask

  task automatic run(input int n, input bit a0, input bit a1, input bit a2, input bit aq);
    for (int i = 0; i < n; i++) tick(a0, a1, a2, aq);
  endtask

  // Async reset with the given inputs held throughout; called just after an edge.
  task automatic do_reset(input bit a0, input bit a1, input bit a2, input bit aq);
    k0 = a0; k1 = a1; k2 = a2; qd = aq;
    rst = 1'b1;
    #1;
    chk("rst_set_mode", set_mode, 1'b0);
    chk("rst_sec_clr",  sec_clr,  1'b0);
    chk("rst_hour_inc", hour_inc, 1'b0);
    chk("rst_min_inc",  min_inc,  1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc = 0; cnt_hour = 0; cnt_min = 0; cnt_sec = 0;
    hour_t.delete(); min_t.delete();
  endtask

  typedef struct {
    bit k0, k1, k2, qd;
    int cycles;
    int e_hour, e_min, e_sec;
    bit e_set;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit r0, r1, r2, rq;

    // Steady-level scenarios from reset: {k0,k1,k2,qd, cycles, hour, min, sec, set_mode}
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0,  40, 0, 0, 1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1,  30, 1, 0, 1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 700, 0, 3, 1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 700, 0, 0, 0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 530, 2, 0, 1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 600, 0, 0, 1, 1'b1};

    #2;
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);

    for (int v = 0; v < 6; v++) begin
      do_reset(1'b0, 1'b0, 1'b0, 1'b0);
      run(vecs[v].cycles, vecs[v].k0, vecs[v].k1, vecs[v].k2, vecs[v].qd);
      chk_int($sformatf("vec%0d_hour_count", v), cnt_hour, vecs[v].e_hour);
      chk_int($sformatf("vec%0d_min_count", v),  cnt_min,  vecs[v].e_min);
      chk_int($sformatf("vec%0d_sec_count", v),  cnt_sec,  vecs[v].e_sec);
      chk_int($sformatf("vec%0d_set_mode", v),   int'(set_mode), int'(vecs[v].e_set));
    end

    // Set mode alone: single sec_clr exactly at cycle 23
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    run(22, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_int("sec_clr_before_23", cnt_sec, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk_int("sec_clr_at_23", int'(sec_clr), 1);
    run(50, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_int("sec_clr_once", cnt_sec, 1);

    // Short qd glitch is rejected
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    run(100, 1'b1, 1'b1, 1'b0, 1'b0);
    run(5,   1'b1, 1'b1, 1'b0, 1'b1);
    run(100, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_int("glitch_hour_count", cnt_hour, 0);

    // Minute hold for 1000 cycles, then release
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    run(1000, 1'b1, 1'b0, 1'b1, 1'b1);
    run(100,  1'b1, 1'b0, 1'b1, 1'b0);
    chk_int("min_hold_count", cnt_min, 6);
    chk_int("min_hold_hour", cnt_hour, 0);
    if (min_t.size() == 6) begin
      chk_int("min_t0", min_t[0], 23);
      chk_int("min_t1", min_t[1], 523);
      chk_int("min_t2", min_t[2], 623);
      chk_int("min_t5", min_t[5], 923);
    end else begin
      chk_int("min_t_size", min_t.size(), 6);
    end

    // Both targets: hour wins; drop k1 mid-hold, cadence continues on minute
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    run(560, 1'b1, 1'b1, 1'b1, 1'b1);
    run(170, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_int("switch_hour_count", cnt_hour, 2);
    chk_int("switch_min_count",  cnt_min,  2);
    if (hour_t.size() == 2 && min_t.size() == 2) begin
      chk_int("switch_hour_t1", hour_t[1], 523);
      chk_int("switch_min_t0",  min_t[0],  623);
      chk_int("switch_min_t1",  min_t[1],  723);
    end else begin
      chk_int("switch_t_size", hour_t.size() + min_t.size(), 4);
    end

    // k0 dropped mid-DELAY: no pulses once set mode falls
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    run(100, 1'b1, 1'b1, 1'b0, 1'b1);
    run(600, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_int("k0_drop_hour_count", cnt_hour, 1);
    chk_int("k0_drop_set_mode", int'(set_mode), 0);

    // k0 low throughout: qd activity gives no increments
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      if ((i / 150) % 2 == 0) tick(1'b0, 1'b1, 1'b1, 1'b1);
      else tick(1'b0, 1'b1, 1'b1, 1'b0);
    end
    chk_int("no_set_inc_count", cnt_hour + cnt_min, 0);

    // Reset in REPEAT with button still held: fresh initial pulse at 23, then +500
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    run(623, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_int("pre_reset_pulse", int'(hour_inc), 1);
    do_reset(1'b1, 1'b1, 1'b0, 1'b1);
    run(530, 1'b1, 1'b1, 1'b0, 1'b1);
    if (hour_t.size() == 2) begin
      chk_int("post_reset_t0", hour_t[0], 23);
      chk_int("post_reset_t1", hour_t[1], 523);
    end else begin
      chk_int("post_reset_count", hour_t.size(), 2);
    end

    // Randomised switch activity against the reference model
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    r0 = 1'b1; r1 = 1'b0; r2 = 1'b1; rq = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 399) == 0) r0 = ~r0;
      if ($urandom_range(0, 299) == 0) r1 = ~r1;
      if ($urandom_range(0, 299) == 0) r2 = ~r2;
      if ($urandom_range(0, 249) == 0) rq = ~rq;
      if ($urandom_range(0, 99) == 0) tick(r0, r1, r2, ~rq);
      else tick(r0, r1, r2, rq);
    end
    chk_int("random_activity_seen", int'((cnt_hour + cnt_min) > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
